// File: rtl/ones_run_ctrl_pkg.sv
// Shared definitions for the run-of-ones session controller: state encoding
// and default counter widths.
package ones_run_ctrl_pkg;

    localparam int DEF_RUN_W = 4;
    localparam int DEF_EVT_W = 8;
    localparam int DEF_WIN_W = 12;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_RUN      = 2'b01;
    localparam logic [1:0] ST_WAIT_ACK = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = ST_IDLE,
        S_RUN      = ST_RUN,
        S_WAIT_ACK = ST_WAIT_ACK
    } state_t;

endpackage

// File: rtl/ones_run_counter.sv
// Consecutive-ones counter with threshold compare; hit flags the sampled 1
// that brings the run length up to the threshold.
module ones_run_counter
    import ones_run_ctrl_pkg::*;
#(
    parameter int RUN_W = DEF_RUN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             data_valid,
    input  logic             data_in,
    input  logic [RUN_W-1:0] threshold,
    output logic             hit
);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W:0]   run_inc;

    // One extra bit so a saturated count can never alias onto the threshold.
    assign run_inc = {1'b0, run_cnt} + {{RUN_W{1'b0}}, 1'b1};
    assign hit     = data_valid && data_in && (run_inc == {1'b0, threshold});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (clr) begin
            run_cnt <= '0;
        end else if (data_valid) begin
            if (!data_in) begin
                run_cnt <= '0;
            end else if (run_cnt != '1) begin
                run_cnt <= run_inc[RUN_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ones_run_ctrl.sv
// Run-of-ones detection session controller: arms on start, counts qualifying
// runs, ends on quota, window expiry or stop, and holds irq until irq_ack.
module ones_run_ctrl
    import ones_run_ctrl_pkg::*;
#(
    parameter int RUN_W = DEF_RUN_W,
    parameter int EVT_W = DEF_EVT_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic [RUN_W-1:0] threshold,
    input  logic [EVT_W-1:0] max_events,
    input  logic [WIN_W-1:0] window,
    input  logic             irq_ack,
    output logic             detect,
    output logic             busy,
    output logic [EVT_W-1:0] evt_count,
    output logic             done,
    output logic             timeout,
    output logic             irq,
    output logic [1:0]       state_dbg
);

    state_t           state, state_nxt;
    logic [RUN_W-1:0] thr_q, thr_nxt;
    logic [EVT_W-1:0] max_q, max_nxt;
    logic [WIN_W-1:0] win_q, win_nxt;
    logic [WIN_W-1:0] win_cnt, win_cnt_nxt;
    logic [EVT_W-1:0] evt_nxt, evt_inc;
    logic             detect_nxt, busy_nxt, irq_nxt, done_nxt, timeout_nxt;
    logic             hit, cnt_clr, quota_hit, window_hit;

    assign state_dbg = state;
    assign cnt_clr   = (state != S_RUN);

    ones_run_counter #(.RUN_W(RUN_W)) u_run_counter (
        .clk        (clk),
        .reset      (reset),
        .clr        (cnt_clr),
        .data_valid (data_valid),
        .data_in    (data_in),
        .threshold  (thr_q),
        .hit        (hit)
    );

    assign evt_inc    = (evt_count == '1) ? evt_count : evt_count + EVT_W'(1);
    assign quota_hit  = hit && (max_q != '0) && (evt_inc == max_q);
    assign window_hit = (win_q != '0) && (win_cnt == win_q - WIN_W'(1));

    always_comb begin
        state_nxt   = state;
        thr_nxt     = thr_q;
        max_nxt     = max_q;
        win_nxt     = win_q;
        win_cnt_nxt = win_cnt;
        evt_nxt     = evt_count;
        detect_nxt  = 1'b0;
        busy_nxt    = busy;
        irq_nxt     = irq;
        done_nxt    = done;
        timeout_nxt = timeout;
        case (state)
            S_IDLE: begin
                if (start) begin
                    // A zero threshold would never match, so it is treated as 1.
                    thr_nxt     = (threshold == '0) ? RUN_W'(1) : threshold;
                    max_nxt     = max_events;
                    win_nxt     = window;
                    win_cnt_nxt = '0;
                    evt_nxt     = '0;
                    done_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = S_RUN;
                end
            end
            S_RUN: begin
                win_cnt_nxt = win_cnt + WIN_W'(1);
                if (stop) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    detect_nxt = hit;
                    if (hit) evt_nxt = evt_inc;
                    // Quota outranks the window when both land on one edge.
                    if (quota_hit) begin
                        done_nxt  = 1'b1;
                        irq_nxt   = 1'b1;
                        state_nxt = S_WAIT_ACK;
                    end else if (window_hit) begin
                        timeout_nxt = 1'b1;
                        irq_nxt     = 1'b1;
                        state_nxt   = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (irq_ack) begin
                    irq_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                irq_nxt   = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            thr_q     <= '0;
            max_q     <= '0;
            win_q     <= '0;
            win_cnt   <= '0;
            evt_count <= '0;
            detect    <= 1'b0;
            busy      <= 1'b0;
            irq       <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            thr_q     <= thr_nxt;
            max_q     <= max_nxt;
            win_q     <= win_nxt;
            win_cnt   <= win_cnt_nxt;
            evt_count <= evt_nxt;
            detect    <= detect_nxt;
            busy      <= busy_nxt;
            irq       <= irq_nxt;
            done      <= done_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_ones_run_ctrl.sv
// Bench for ones_run_ctrl: directed sessions, an event-level reference model
// compared every cycle, and literal expectations for key scenarios.
module tb_ones_run_ctrl;

    localparam int RUN_W = 4;
    localparam int EVT_W = 8;
    localparam int WIN_W = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             data_in = 1'b0;
    logic             data_valid = 1'b0;
    logic [RUN_W-1:0] threshold = '0;
    logic [EVT_W-1:0] max_events = '0;
    logic [WIN_W-1:0] window = '0;
    logic             irq_ack = 1'b0;
    logic             detect, busy, done, timeout, irq;
    logic [EVT_W-1:0] evt_count;
    logic [1:0]       state_dbg;

    ones_run_ctrl #(.RUN_W(RUN_W), .EVT_W(EVT_W), .WIN_W(WIN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .data_in    (data_in),
        .data_valid (data_valid),
        .threshold  (threshold),
        .max_events (max_events),
        .window     (window),
        .irq_ack    (irq_ack),
        .detect     (detect),
        .busy       (busy),
        .evt_count  (evt_count),
        .done       (done),
        .timeout    (timeout),
        .irq        (irq),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int det_seen = 0;
    int d0, first;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 waiting for ack.
    int   m_mode, m_run, m_evt, m_elapsed, m_thr, m_max, m_win;
    logic m_detect, m_irq, m_done, m_timeout, fire;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_run = 0; m_evt = 0; m_elapsed = 0;
            m_thr = 0; m_max = 0; m_win = 0;
            m_detect = 0; m_irq = 0; m_done = 0; m_timeout = 0;
        end else begin
            m_detect = 0;
            if (m_mode == 0) begin
                if (start) begin
                    m_thr = (threshold == 0) ? 1 : int'(threshold);
                    m_max = int'(max_events);
                    m_win = int'(window);
                    m_evt = 0; m_done = 0; m_timeout = 0;
                    m_run = 0; m_elapsed = 0;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                fire = 0;
                m_elapsed++;
                if (data_valid) begin
                    if (data_in) begin
                        m_run++;
                        fire = (m_run == m_thr);
                    end else begin
                        m_run = 0;
                    end
                end
                if (stop) begin
                    m_mode = 0;
                end else begin
                    m_detect = fire;
                    if (fire && m_evt < 255) m_evt++;
                    if (fire && m_max != 0 && m_evt == m_max) begin
                        m_done = 1; m_irq = 1; m_mode = 2;
                    end else if (m_win != 0 && m_elapsed == m_win) begin
                        m_timeout = 1; m_irq = 1; m_mode = 2;
                    end
                end
            end else begin
                if (irq_ack) begin
                    m_irq = 0;
                    m_mode = 0;
                end
            end
        end
    end

    // Every-cycle compare: detect, busy, irq, done, timeout, state, evt_count.
    always @(negedge clk) begin
        chk("cycle", {detect, busy, irq, done, timeout, state_dbg, evt_count},
            {m_detect, m_mode != 0, m_irq, m_done, m_timeout, 2'(m_mode), 8'(m_evt)});
        if (detect) det_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int thr, input int mx, input int win);
        threshold  = thr[RUN_W-1:0];
        max_events = mx[EVT_W-1:0];
        window     = win[WIN_W-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic v, input logic d);
        data_valid = v;
        data_in    = d;
        tick();
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        data_in    = 1'b0;
        repeat (n) tick();
    endtask

    task automatic abort();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {detect, busy, irq, done, timeout, state_dbg, evt_count}, 0);
        reset = 1'b1;
        tick();

        // Two qualifying runs in 1,1,1,1,0,1,1,1 with threshold 3.
        d0 = det_seen;
        do_start(3, 0, 0);
        send(1, 1); send(1, 1); send(1, 1); send(1, 1);
        send(1, 0); send(1, 1); send(1, 1); send(1, 1);
        idle(2);
        chk("t1_detects", det_seen - d0, 2);
        chk("t1_evt", evt_count, 2);
        chk("t1_irq", irq, 0);
        abort();
        chk("t1_busy_after_stop", busy, 0);
        chk("t1_evt_kept", evt_count, 2);

        // Gaps of invalid samples do not break a run.
        d0 = det_seen;
        do_start(2, 0, 0);
        send(1, 1); send(0, 0); send(0, 1); send(0, 0); send(1, 1);
        idle(2);
        chk("t2_gap_detects", det_seen - d0, 1);
        abort();

        // A sampled 0 does break it.
        d0 = det_seen;
        do_start(2, 0, 0);
        send(1, 1); send(1, 0); send(1, 1);
        idle(2);
        chk("t2_zero_detects", det_seen - d0, 0);
        abort();

        // Quota of 2: second detect coincides with done and irq.
        do_start(2, 2, 0);
        send(1, 1); send(1, 1); send(1, 0); send(1, 1); send(1, 1);
        chk("t3_detect", detect, 1);
        chk("t3_done", done, 1);
        chk("t3_irq", irq, 1);
        chk("t3_state", state_dbg, 2'b10);
        data_valid = 1'b1;
        data_in    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                threshold = 4'd1;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            chk("t3_irq_held", irq, 1);
        end
        data_valid = 1'b0;
        chk("t3_evt_held", evt_count, 2);
        ack();
        chk("t3_busy_after_ack", busy, 0);
        chk("t3_irq_after_ack", irq, 0);
        chk("t3_done_sticky", done, 1);

        // Window of 10 with no ones: timeout exactly 10 cycles after entry.
        do_start(1, 0, 10);
        data_valid = 1'b1;
        data_in    = 1'b0;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (timeout && first == 0) first = i;
        end
        data_valid = 1'b0;
        chk("t4_timeout_cycle", first, 10);
        chk("t4_irq", irq, 1);
        chk("t4_done", done, 0);
        ack();

        // Quota and window on the same edge: done wins.
        do_start(1, 1, 10);
        data_valid = 1'b1;
        data_in    = 1'b0;
        repeat (9) tick();
        data_in = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("t4b_done", done, 1);
        chk("t4b_timeout", timeout, 0);
        chk("t4b_irq", irq, 1);
        ack();

        // Stop on the edge that would qualify a run suppresses detect.
        d0 = det_seen;
        do_start(3, 0, 0);
        send(1, 1); send(1, 1); send(1, 1); send(1, 0); send(1, 1); send(1, 1);
        stop = 1'b1;
        send(1, 1);
        stop = 1'b0;
        idle(2);
        chk("t5_detects", det_seen - d0, 1);
        chk("t5_evt_kept", evt_count, 1);
        chk("t5_busy", busy, 0);
        chk("t5_irq", irq, 0);
        chk("t5_state", state_dbg, 2'b00);
        ack();
        chk("t5_ack_ignored", {busy, irq, state_dbg}, 0);

        // Reset mid-RUN clears outputs immediately.
        do_start(2, 3, 0);
        send(1, 1); send(1, 1); send(1, 1);
        data_valid = 1'b0;
        #2 reset = 1'b0;
        #1 chk("t6_reset_run", {detect, busy, irq, done, timeout, state_dbg, evt_count}, 0);
        tick();
        reset = 1'b1;

        // Reset mid-WAIT_ACK clears irq immediately.
        do_start(1, 1, 0);
        send(1, 1);
        data_valid = 1'b0;
        chk("t6_irq_before", irq, 1);
        #2 reset = 1'b0;
        #1 chk("t6_reset_wait", {detect, busy, irq, done, timeout, state_dbg, evt_count}, 0);
        tick();
        reset = 1'b1;

        // Threshold 0 acts as 1: every isolated 1 is detected.
        d0 = det_seen;
        do_start(0, 0, 0);
        send(1, 1); send(1, 0); send(1, 1); send(1, 1); send(1, 0); send(1, 1);
        idle(2);
        chk("t7_detects", det_seen - d0, 3);
        chk("t7_evt", evt_count, 3);
        abort();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ones_run_ctrl.md
Name: ones_run_ctrl

Overview:
Controller that sequences a run-of-ones detection session on a serial bit stream. Software arms it with a programmable run length, event quota and time window. It counts qualifying runs, stops on quota, time window or abort, and raises a held interrupt that software clears with an acknowledge. It sits between the serial input front-end and the register/interrupt block.

Parameters:
RUN_W, 4, width of the run-length threshold and the consecutive-ones counter
EVT_W, 8, width of the event quota and the event counter
WIN_W, 12, width of the session window (clock cycles)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low
start  in  1  one-cycle pulse, arms a session (honoured only in IDLE)
stop  in  1  abort the running session
data_in  in  1  serial data bit
data_valid  in  1  data_in is sampled only when 1
threshold  in  RUN_W  required run length, latched at start
max_events  in  EVT_W  event quota, latched at start
window  in  WIN_W  session length in cycles, latched at start
irq_ack  in  1  clears irq
detect  out  1  one-cycle pulse per qualifying run
busy  out  1  session active (RUN or WAIT_ACK)
evt_count  out  EVT_W  runs detected in current/last session
done  out  1  sticky: session ended by quota
timeout  out  1  sticky: session ended by window expiry
irq  out  1  level interrupt, held until irq_ack

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; run/window counters 0; latched config 0.
- All outputs are registered (Moore style).
- States: IDLE, RUN, WAIT_ACK. Binary encoding 2'b00 / 2'b01 / 2'b10; 2'b11 is illegal and recovers to IDLE.
- IDLE:
  - start=1: latch threshold, max_events and window. A threshold of 0 is latched as 1.
  - Same edge: clear run_cnt, win_cnt, evt_count, done and timeout.
  - Next state RUN; busy=1 from the following cycle.
  - Other inputs are ignored in IDLE.
- RUN, per clock:
  - win_cnt increments every cycle.
  - If data_valid=1 and data_in=1: run_cnt increments, saturating at 2^RUN_W-1.
  - If data_valid=1 and data_in=0: run_cnt=0.
  - If data_valid=0: run_cnt holds, so gaps do not break a run.
  - When a sampled 1 makes run_cnt equal to the latched threshold: detect=1 in the next cycle for exactly one cycle, and evt_count increments (saturating).
  - Further ones in the same run produce no further detect. A 0 is required to re-qualify.
- RUN exit priority, highest first:
  1. stop=1: go to IDLE, busy=0, no irq. done, timeout and evt_count keep their values. If detect would fire on this edge, it is suppressed.
  2. max_events≠0 and the increment reaches max_events: done=1, irq=1, go to WAIT_ACK. The detect for this event is still issued.
  3. window≠0 and win_cnt reaches window-1: timeout=1, irq=1, go to WAIT_ACK.
  - If quota and window are hit on the same edge: done=1, timeout=0.
  - max_events=0 disables the quota; window=0 disables the timeout. With both 0 the session ends only by stop.
- WAIT_ACK:
  - busy=1, irq=1, inputs ignored.
  - irq_ack=1: irq=0, busy=0, go to IDLE next cycle.
  - start in WAIT_ACK is ignored.
- start while busy is ignored. irq_ack outside WAIT_ACK is ignored.
- Reset mid-session returns everything to reset values immediately, with no irq.

Decomposition:
- Shared package holds:
  - State encoding localparams ST_IDLE, ST_RUN, ST_WAIT_ACK.
  - Default widths RUN_W, EVT_W, WIN_W.
- One natural sub-module, ones_run_counter: run_cnt plus threshold compare. Ports: clk, reset, clr, data_valid, data_in, threshold; output hit (one-cycle pulse).
- Window/event counters and the FSM stay in the top module.

Test Plan:
- threshold=3, max=0, window=0; valid stream 1,1,1,1,0,1,1,1 → two detect pulses, 1 cycle after the 3rd and 8th bits; evt_count=2; irq=0.
- threshold=2; stream 1,(valid=0 ×3),1 → one detect; a 0 inserted between the two ones instead → no detect.
- threshold=2, max_events=2; stream 1,1,0,1,1 → 2nd detect coincides with done=1, irq=1, state WAIT_ACK. irq stays high 5 cycles until irq_ack, then busy=0.
- window=10, stream all 0 → timeout=1 and irq=1 exactly 10 cycles after RUN entry. Repeat with the quota reached on the same edge → done=1, timeout=0.
- Abort: stop mid-run with run_cnt=threshold-1 and a 1 on the same edge → IDLE, no detect, no irq, evt_count kept. start during WAIT_ACK → no effect.
- Reset pulse mid-RUN and mid-WAIT_ACK → all outputs 0 asynchronously. A new start works normally afterwards. threshold=0 behaves as 1 (every isolated 1 is detected).
